// File: rtl/pla_stim_pkg.sv
// pla_stim_pkg: shared types and constants for the PLA stimulus/response harness.
//   - state_t      : run controller states (IDLE, DRIVE, DONE)
//   - DEF_SEED     : default LFSR reset/fallback seed
//   - DEF_LTAPS    : default Galois LFSR tap mask (x^10+x^7+1)
//   - DEF_MTAPS    : default MISR tap mask (x^8+x^4+x^3+x^2+1)
//   - popcount()   : number of set bits in a 32-bit word
package pla_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [9:0] DEF_SEED  = 10'h001;
  localparam logic [9:0] DEF_LTAPS = 10'h240;
  localparam logic [7:0] DEF_MTAPS = 8'h1D;

  // Bit count of a word; callers zero-extend narrower vectors to 32 bits.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] acc;
    acc = 6'd0;
    for (int i = 0; i < 32; i++) begin
      acc = acc + {5'd0, v[i]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/pla_misr.sv
// pla_misr: multiple-input signature register that compacts the benchmark
// responses into an OUT_W-bit signature.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset (signature -> 0)
//   clear     in   synchronous clear at the start of a run
//   enable    in   absorb resp this cycle
//   resp      in   OUT_W response word
//   signature out  OUT_W current signature
module pla_misr
  import pla_stim_pkg::*;
#(
  parameter int               OUT_W = 8,
  parameter logic [OUT_W-1:0] MTAPS = DEF_MTAPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [OUT_W-1:0] resp,
  output logic [OUT_W-1:0] signature
);

  logic [OUT_W-1:0] sig_r;
  logic [OUT_W-1:0] sig_next_s;

  // Shift left, fold the outgoing MSB back through the taps, then mix in resp.
  always_comb begin
    sig_next_s = {sig_r[OUT_W-2:0], 1'b0} ^ resp;
    if (sig_r[OUT_W-1]) begin
      sig_next_s = sig_next_s ^ MTAPS;
    end else begin
      sig_next_s = sig_next_s;
    end
  end

  // Signature register: clear has priority over absorbing a new response.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_r <= {OUT_W{1'b0}};
    end else if (clear) begin
      sig_r <= {OUT_W{1'b0}};
    end else if (enable) begin
      sig_r <= sig_next_s;
    end
  end

  assign signature = sig_r;

endmodule

// File: rtl/pla_stim_driver.sv
// pla_stim_driver: drives pseudo-random vectors into a combinational PLA
// benchmark, compacts its responses in a MISR and counts input/output bit
// toggles (saturating) as switching-activity figures.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, num_vec  begin a run of num_vec vectors (accepted in IDLE only)
//   hold            stall the run while high
//   seed_load, seed reload the LFSR in IDLE (seed 0 falls back to SEED)
//   resp            benchmark outputs for the vector currently on stim
//   stim            benchmark inputs (zero outside DRIVE)
//   busy, done      run in progress / one-cycle end-of-run pulse
//   signature       MISR result
//   in_toggles      stim bit flips over the run
//   out_toggles     resp bit flips over the run
module pla_stim_driver
  import pla_stim_pkg::*;
#(
  parameter int               IN_W   = 10,
  parameter int               OUT_W  = 8,
  parameter int               NVEC_W = 16,
  parameter int               CNT_W  = 24,
  parameter logic [IN_W-1:0]  SEED   = DEF_SEED,
  parameter logic [IN_W-1:0]  LTAPS  = DEF_LTAPS,
  parameter logic [OUT_W-1:0] MTAPS  = DEF_MTAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NVEC_W-1:0] num_vec,
  input  logic              hold,
  input  logic              seed_load,
  input  logic [IN_W-1:0]   seed,
  input  logic [OUT_W-1:0]  resp,
  output logic [IN_W-1:0]   stim,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  signature,
  output logic [CNT_W-1:0]  in_toggles,
  output logic [CNT_W-1:0]  out_toggles
);

  state_t            state_r;
  state_t            next_state_s;
  logic              busy_r;
  logic              done_r;
  logic [IN_W-1:0]   lfsr_r;
  logic [IN_W-1:0]   lfsr_next_s;
  logic [IN_W-1:0]   seed_val_s;
  logic [NVEC_W-1:0] num_vec_r;
  logic [NVEC_W-1:0] vec_cnt_r;
  logic [IN_W-1:0]   stim_prev_r;
  logic [OUT_W-1:0]  resp_prev_r;
  logic [CNT_W-1:0]  in_tog_r;
  logic [CNT_W-1:0]  out_tog_r;
  logic [IN_W-1:0]   stim_s;
  logic              accept_s;
  logic              seed_ld_s;
  logic              advance_s;
  logic              last_s;

  // Add a small increment, pinning at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [5:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-5){1'b0}}, inc};
    if (sum[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  // stim is a plain AND of registers so the benchmark sees glitch-free inputs.
  assign stim_s = lfsr_r & {IN_W{busy_r}};
  assign last_s = (vec_cnt_r == (num_vec_r - NVEC_W'(1)));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-cycle control strobes; start outranks seed_load.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    seed_ld_s    = 1'b0;
    advance_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (num_vec == {NVEC_W{1'b0}}) begin
            next_state_s = DONE;
          end else begin
            next_state_s = DRIVE;
          end
        end else if (seed_load) begin
          seed_ld_s    = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = IDLE;
        end
      end
      DRIVE: begin
        if (!hold) begin
          advance_s = 1'b1;
          if (last_s) begin
            next_state_s = DONE;
          end else begin
            next_state_s = DRIVE;
          end
        end else begin
          next_state_s = DRIVE;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // LFSR step and seed selection (a zero seed would lock the LFSR up).
  always_comb begin
    lfsr_next_s = lfsr_r >> 1;
    if (lfsr_r[0]) begin
      lfsr_next_s = lfsr_next_s ^ LTAPS;
    end else begin
      lfsr_next_s = lfsr_next_s;
    end
    if (seed == {IN_W{1'b0}}) begin
      seed_val_s = SEED;
    end else begin
      seed_val_s = seed;
    end
  end

  // busy/done are registered from the next state so they align with stim.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s == DRIVE);
      done_r <= (next_state_s == DONE);
    end
  end

  // LFSR, vector counter, previous-vector history and toggle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r      <= SEED;
      num_vec_r   <= {NVEC_W{1'b0}};
      vec_cnt_r   <= {NVEC_W{1'b0}};
      stim_prev_r <= {IN_W{1'b0}};
      resp_prev_r <= {OUT_W{1'b0}};
      in_tog_r    <= {CNT_W{1'b0}};
      out_tog_r   <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      num_vec_r   <= num_vec;
      vec_cnt_r   <= {NVEC_W{1'b0}};
      stim_prev_r <= {IN_W{1'b0}};
      resp_prev_r <= {OUT_W{1'b0}};
      in_tog_r    <= {CNT_W{1'b0}};
      out_tog_r   <= {CNT_W{1'b0}};
    end else if (seed_ld_s) begin
      lfsr_r <= seed_val_s;
    end else if (advance_s) begin
      lfsr_r      <= lfsr_next_s;
      vec_cnt_r   <= vec_cnt_r + NVEC_W'(1);
      stim_prev_r <= stim_s;
      resp_prev_r <= resp;
      in_tog_r    <= sat_add(in_tog_r, popcount(32'(stim_s ^ stim_prev_r)));
      out_tog_r   <= sat_add(out_tog_r, popcount(32'(resp ^ resp_prev_r)));
    end
  end

  pla_misr #(
    .OUT_W (OUT_W),
    .MTAPS (MTAPS)
  ) u_misr (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept_s),
    .enable    (advance_s),
    .resp      (resp),
    .signature (signature)
  );

  assign stim        = stim_s;
  assign busy        = busy_r;
  assign done        = done_r;
  assign in_toggles  = in_tog_r;
  assign out_toggles = out_tog_r;

endmodule

// File: doc/pla_stim_driver.md
# pla_stim_driver

Sequential stimulus/response harness that sits on the other end of a combinational PLA benchmark netlist (10 inputs, 8 outputs). It drives pseudo-random input vectors, absorbs the benchmark's outputs into a MISR signature, and counts input and output bit toggles as switching-activity figures for power-aware synthesis runs. One run is started by a pulse and ends with a one-cycle done pulse; results hold until the next run.

## Interface
- IN_W, 10, benchmark input width (stimulus width)
- OUT_W, 8, benchmark output width (response width)
- NVEC_W, 16, width of vector-count request
- CNT_W, 24, width of toggle counters (saturating)
- SEED, 10'h001, LFSR reset/fallback seed (must be nonzero)
- LTAPS, 10'h240, Galois LFSR tap mask (x^10+x^7+1, maximal)
- MTAPS, 8'h1D, MISR tap mask (x^8+x^4+x^3+x^2+1)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin run (sampled in IDLE only)
- num_vec  in  NVEC_W  vectors to apply; sampled with start
- hold  in  1  stall: freezes DRIVE progress while high
- seed_load  in  1  load seed into LFSR (IDLE only)
- seed  in  IN_W  seed value; 0 is replaced by SEED
- resp  in  OUT_W  benchmark outputs (combinational function of stim)
- stim  out  IN_W  benchmark inputs
- busy  out  1  high in DRIVE
- done  out  1  one-cycle pulse at run end
- signature  out  OUT_W  MISR result
- in_toggles  out  CNT_W  sum of stim bit flips over run
- out_toggles  out  CNT_W  sum of resp bit flips over run

## Operation
- States: IDLE, DRIVE, DONE. Reset -> IDLE; stim=0, busy=0, done=0, signature=0, both toggle counters 0, LFSR=SEED, vector counter 0.
- IDLE: start=1 -> clear signature, toggle counters, vector counter, stim_prev=0, resp_prev=0; go DRIVE if num_vec>0, else go DONE directly. start has priority over seed_load in the same cycle (seed_load ignored).
- seed_load in IDLE without start: LFSR <= (seed==0 ? SEED : seed). seed_load outside IDLE ignored.
- stim = busy ? LFSR : 0 (AND of registers, no other logic).
- DRIVE, hold=0 ("advance"): signature <= ((signature<<1) ^ (signature[OUT_W-1] ? MTAPS : 0) ^ resp) truncated to OUT_W; in_toggles += popcount(stim ^ stim_prev); out_toggles += popcount(resp ^ resp_prev); stim_prev<=stim; resp_prev<=resp; LFSR <= (LFSR>>1) ^ (LFSR[0] ? LTAPS : 0); counter+1. After the num_vec-th advance -> DONE.
- DRIVE, hold=1: no register changes; stim stays stable.
- DONE: done=1, busy=0 for exactly one cycle -> IDLE. Results hold until next accepted start.
- start while busy or in DONE: ignored.
- Toggle counters saturate at 2^CNT_W-1, never wrap.
- LFSR is not reseeded by start: consecutive runs continue the sequence.
- rst mid-run: immediate return to reset state next edge, no done pulse.

## Timing
- Edge E0: start sampled in IDLE -> busy=1 from cycle 1; stim = vector 1 during cycle 1.
- resp sampled at the end of the cycle its stim is presented (same-cycle combinational path; DUT must meet one clock).
- Without hold: N vectors occupy cycles 1..N; done high in cycle N+1; busy low in cycle N+1; IDLE in N+2, new start accepted there.
- Each hold cycle extends the run by one cycle.
- num_vec=0: done in cycle 1, results all zero.

## Structure
- Package pla_stim_pkg: state enum (IDLE, DRIVE, DONE), default LTAPS/MTAPS/SEED constants, popcount function.
- One sub-module: pla_misr (OUT_W, MTAPS; clear, enable, resp -> signature).
- FSM, LFSR, counters live in the top.

## Test plan
- Reset, SEED=0x001, start, num_vec=3, resp tied 0 -> stim 0x001, 0x240, 0x120 in cycles 1-3; in_toggles=8, out_toggles=0, signature=0x00, done in cycle 4.
- resp tied 0x01, num_vec=2 -> signature 0x03, out_toggles=1.
- num_vec=3 with hold high in cycle 2 -> stim 0x240 held two cycles; results identical to scenario 1; done in cycle 5.
- seed_load seed=0 then start num_vec=1 -> stim 0x001 (fallback); seed_load seed=0x3FF then num_vec=1 -> stim 0x3FF, in_toggles=10.
- start with num_vec=0 -> done next cycle, all results 0; start asserted during DRIVE -> ignored, run length unchanged.
- rst asserted mid-DRIVE -> next cycle stim=0, busy=0, no done, counters 0; subsequent run replays from 0x001.
